ahb5_lite_interconnect: RTL and testbench
=========================================

# ahb5_lite_interconnect

Parametrised single-master, multi-slave AHB5-Lite interconnect: address decoder, secure-region filter, built-in default slave and data-phase response multiplexer. It sits between one AHB5-Lite master and `NUM_SLAVES` slaves and replaces a fixed one-slave, one-region decode. Decode failures and non-secure accesses to secure-only regions are answered with a two-cycle AHB ERROR response. A saturating error counter and last-error address register are exposed for debug.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `NUM_SLAVES`, 4: number of slave ports, 1–16.
- `BASE_ADDR`, 32'h0000_0000: base address of slave 0. Must be aligned to 2^`REGION_SHIFT`.
- `REGION_SHIFT`, 16: each slave region is 2^`REGION_SHIFT` bytes.
- `SEC_MASK`, 0: bit i = 1 makes slave i secure-only.

Ports:
- `hclk`  in  1  clock.
- `hresetn`  in  1  asynchronous active-low reset.
- `m_haddr`  in  `ADDR_WIDTH`  master address.
- `m_htrans`  in  2  master transfer type.
- `m_hnonsec`  in  1  1 = non-secure transfer.
- `m_hrdata`  out  `DATA_WIDTH`  muxed read data.
- `m_hready`  out  1  system HREADY; also drives `s_hready`.
- `m_hresp`  out  1  muxed response, 1 = ERROR.
- `s_hsel`  out  `NUM_SLAVES`  one-hot slave select.
- `s_hready`  out  1  HREADY to all slaves (hready_in).
- `s_hrdata`  in  `NUM_SLAVES`*`DATA_WIDTH`  slave i occupies bits [i*DW +: DW].
- `s_hreadyout`  in  `NUM_SLAVES`  per-slave HREADYOUT.
- `s_hresp`  in  `NUM_SLAVES`  per-slave HRESP.
- `err_clr`  in  1  single-cycle pulse; clears `err_count`.
- `err_count`  out  8  saturating count of default-slave ERROR responses.
- `err_addr`  out  `ADDR_WIDTH`  address of the most recent errored transfer.

HADDR, HWRITE, HSIZE, HBURST and HWDATA are broadcast to the slaves outside this block and are not ported.

## Operation
- **Region index:** idx = (`m_haddr` >> `REGION_SHIFT`) − (`BASE_ADDR` >> `REGION_SHIFT`). Compute it in `ADDR_WIDTH` bits. An address below `BASE_ADDR` or with idx ≥ `NUM_SLAVES` is unmapped.
- **Address-phase decode (combinational):**
  - `s_hsel[idx]` = 1 when mapped and not (`SEC_MASK[idx]` & `m_hnonsec`).
  - This holds independent of `m_htrans` and `m_hready`.
  - All other bits are 0.
- **Default select:** asserted when the address is unmapped or is a secure violation.
- **Data-phase select register `dsel`:**
  - Encodings: slave i, DEFAULT, NONE.
  - On `m_hready` = 1, load the address-phase selection. Load NONE when `m_htrans` is IDLE or BUSY and the selection is DEFAULT.
  - Hold while `m_hready` = 0.
- **Response mux:**
  - `dsel` = slave i: `m_hready` = `s_hreadyout[i]`, `m_hresp` = `s_hresp[i]`, `m_hrdata` = slave i data.
  - `dsel` = NONE: `m_hready` = 1, `m_hresp` = 0, `m_hrdata` = 0.
  - `dsel` = DEFAULT: driven by the default-slave FSM; `m_hrdata` = 0.
- **Default-slave FSM.** States DS_IDLE, DS_ERR1, DS_ERR2.
  - DS_IDLE → DS_ERR1 when `m_hready` & default selected & `m_htrans` ∈ {NONSEQ, SEQ}.
  - DS_ERR1 → DS_ERR2 unconditionally. In DS_ERR1: `m_hready` = 0, `m_hresp` = 1.
  - In DS_ERR2: `m_hready` = 1, `m_hresp` = 1.
  - DS_ERR2 → DS_ERR1 if another active default-selected transfer is presented this cycle; otherwise DS_ERR2 → DS_IDLE.
- **Error logging:** on every entry to DS_ERR1:
  - `err_addr` ← `m_haddr`.
  - `err_count` increments, saturating at 255.
  - If `err_clr` and an entry coincide, `err_count` = 1.
  - `err_clr` alone sets `err_count` to 0 and leaves `err_addr` unchanged.

## Timing
- **Reset values:** `dsel` = NONE; FSM = DS_IDLE; `m_hready` = 1; `m_hresp` = 0; `m_hrdata` = 0; `err_count` = 0; `err_addr` = 0.
- `s_hsel` follows its inputs combinationally, including during reset.
- Reset assertion mid-transfer (e.g. in DS_ERR1) forces the reset values immediately and asynchronously.
- **Latency:**
  - Decode to `s_hsel`: 0 cycles (combinational).
  - Response mux: combinational from slave outputs through registered `dsel`.
  - Mapped zero-wait transfer: data phase completes 1 cycle after the address phase.
  - Error transfer: exactly 2 data-phase cycles.
- **Pipelining:** back-to-back transfers to different slaves need no extra cycles. The next address phase is presented while the current data phase stalls; `s_hready` = 0 prevents the next slave from sampling it.

## Test plan
Configuration for all scenarios: `NUM_SLAVES`=4, `BASE_ADDR`=0, `REGION_SHIFT`=16, `SEC_MASK`=4'b1000.

1. NONSEQ write to 0x0001_0004, `m_hnonsec`=0, slave 1 zero-wait → `s_hsel`=4'b0010; next cycle `m_hready`=1, `m_hresp`=0.
2. NONSEQ read of 0x0005_0000 (unmapped) → `s_hsel`=0; data phase cycle 1 `m_hready`=0/`m_hresp`=1, cycle 2 `m_hready`=1/`m_hresp`=1; `err_count`=1, `err_addr`=0x0005_0000.
3. Read of 0x0003_0000:
   - With `m_hnonsec`=1 → `s_hsel`=0 and a two-cycle ERROR.
   - Repeated with `m_hnonsec`=0 → `s_hsel`=4'b1000, `m_hrdata`=slave 3 data 0xDEAD_BEEF, OKAY.
4. Read from slave 2 holding `s_hreadyout[2]`=0 for 3 cycles, with the next address 0x0000_0010 pending → `s_hsel`=4'b0001 throughout; `m_hrdata` from slave 2 on the 4th cycle; slave 0 data phase starts the following cycle.
5. Error logging and saturation:
   - 256 back-to-back errors with IDLE between each → `err_count` stops at 255.
   - Then `err_clr` coinciding with a new error entry → `err_count`=1.
6. `hresetn` asserted during DS_ERR1 → `m_hready`=1, `m_hresp`=0, `err_count`=0 without waiting for a clock edge; after release, an IDLE to an unmapped address gives an OKAY zero-wait response.

Source files
------------

// File: rtl/ahb5_lite_interconnect.sv
// ---------------------------------------------------------------------------
// ahb5_lite_interconnect
//
// Single-master, multi-slave AHB5-Lite interconnect. Decodes the master
// address into one of NUM_SLAVES equally sized regions starting at
// BASE_ADDR. Non-secure accesses to secure-only regions are blocked. Holds
// the data-phase selection in a register and multiplexes the selected
// slave's response back to the master. Unmapped addresses and secure
// violations are routed to a built-in default slave, which answers with a
// two-cycle ERROR response. A saturating error counter and the last errored
// address are kept for debug.
//
// Ports
//   hclk, hresetn     clock, asynchronous active-low reset
//   m_haddr           master address (address phase)
//   m_htrans          master transfer type
//   m_hnonsec         1 = non-secure transfer
//   m_hrdata          muxed read data to the master
//   m_hready          system HREADY (also fed to the slaves as s_hready)
//   m_hresp           muxed response, 1 = ERROR
//   s_hsel            one-hot slave select (combinational decode)
//   s_hready          HREADY to all slaves
//   s_hrdata          packed slave read data, slave i at [i*DW +: DW]
//   s_hreadyout       per-slave HREADYOUT
//   s_hresp           per-slave HRESP
//   err_clr           pulse, clears err_count
//   err_count         saturating count of default-slave ERROR responses
//   err_addr          address of the most recent errored transfer
// ---------------------------------------------------------------------------
module ahb5_lite_interconnect #(
  parameter int                     ADDR_WIDTH   = 32,
  parameter int                     DATA_WIDTH   = 32,
  parameter int                     NUM_SLAVES   = 4,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = '0,
  parameter int                     REGION_SHIFT = 16,
  parameter logic [NUM_SLAVES-1:0]  SEC_MASK     = '0
) (
  input  logic                             hclk,
  input  logic                             hresetn,
  input  logic [ADDR_WIDTH-1:0]            m_haddr,
  input  logic [1:0]                       m_htrans,
  input  logic                             m_hnonsec,
  output logic [DATA_WIDTH-1:0]            m_hrdata,
  output logic                             m_hready,
  output logic                             m_hresp,
  output logic [NUM_SLAVES-1:0]            s_hsel,
  output logic                             s_hready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata,
  input  logic [NUM_SLAVES-1:0]            s_hreadyout,
  input  logic [NUM_SLAVES-1:0]            s_hresp,
  input  logic                             err_clr,
  output logic [7:0]                       err_count,
  output logic [ADDR_WIDTH-1:0]            err_addr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_REGION = BASE_ADDR >> REGION_SHIFT;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    DSEL_NONE,
    DSEL_DEFAULT,
    DSEL_SLAVE
  } dsel_kind_t;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_t;

  // -------------------------------------------------------------------------
  // Address-phase decode
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] region_idx;
  logic                  addr_mapped;
  logic [NUM_SLAVES-1:0] hit;
  logic                  default_sel;
  logic [IDX_W-1:0]      hit_idx;
  logic                  active_trans;

  // Region index computed modulo 2^ADDR_WIDTH; addresses below the base wrap
  // to large values, but are also rejected explicitly by the compare.
  assign region_idx  = (m_haddr >> REGION_SHIFT) - BASE_REGION;
  assign addr_mapped = (m_haddr >= BASE_ADDR) &&
                       (region_idx < ADDR_WIDTH'(NUM_SLAVES));

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
      assign hit[gi] = addr_mapped &&
                       (region_idx == ADDR_WIDTH'(gi)) &&
                       !(SEC_MASK[gi] && m_hnonsec);
    end
  endgenerate

  assign s_hsel       = hit;
  assign default_sel  = ~|hit;
  assign active_trans = (m_htrans == HTRANS_NONSEQ) || (m_htrans == HTRANS_SEQ);

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (hit[i]) begin
        hit_idx = IDX_W'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Data-phase select register
  // -------------------------------------------------------------------------
  dsel_kind_t       dsel_kind_reg, dsel_kind_next;
  logic [IDX_W-1:0] dsel_idx_reg, dsel_idx_next;

  always_comb begin
    dsel_kind_next = dsel_kind_reg;
    dsel_idx_next  = dsel_idx_reg;
    if (m_hready) begin
      if (!default_sel) begin
        dsel_kind_next = DSEL_SLAVE;
        dsel_idx_next  = hit_idx;
      end else if (active_trans) begin
        dsel_kind_next = DSEL_DEFAULT;
      end else begin
        // IDLE/BUSY to nowhere: no slave owns the data phase, answer OKAY.
        dsel_kind_next = DSEL_NONE;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dsel_kind_reg <= DSEL_NONE;
      dsel_idx_reg  <= '0;
    end else begin
      dsel_kind_reg <= dsel_kind_next;
      dsel_idx_reg  <= dsel_idx_next;
    end
  end

  // -------------------------------------------------------------------------
  // Default-slave FSM
  // -------------------------------------------------------------------------
  ds_state_t ds_state_reg, ds_state_next;
  logic      ds_enter;
  logic      err_entry;

  assign ds_enter = m_hready && default_sel && active_trans;

  always_comb begin
    ds_state_next = ds_state_reg;
    case (ds_state_reg)
      DS_IDLE: if (ds_enter) ds_state_next = DS_ERR1;
      DS_ERR1: ds_state_next = DS_ERR2;
      DS_ERR2: ds_state_next = ds_enter ? DS_ERR1 : DS_IDLE;
      default: ds_state_next = DS_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ds_state_reg <= DS_IDLE;
    end else begin
      ds_state_reg <= ds_state_next;
    end
  end

  assign err_entry = (ds_state_next == DS_ERR1) && (ds_state_reg != DS_ERR1);

  // -------------------------------------------------------------------------
  // Response multiplexer
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] s_rdata_arr [NUM_SLAVES];

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_rdata
      assign s_rdata_arr[gi] = s_hrdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    m_hready = 1'b1;
    m_hresp  = 1'b0;
    m_hrdata = '0;
    case (dsel_kind_reg)
      DSEL_SLAVE: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (dsel_idx_reg == IDX_W'(i)) begin
            m_hready = s_hreadyout[i];
            m_hresp  = s_hresp[i];
            m_hrdata = s_rdata_arr[i];
          end
        end
      end
      DSEL_DEFAULT: begin
        // First error cycle stalls, second completes; both flag ERROR.
        m_hready = (ds_state_reg != DS_ERR1);
        m_hresp  = (ds_state_reg != DS_IDLE);
      end
      default: begin
        m_hready = 1'b1;
        m_hresp  = 1'b0;
      end
    endcase
  end

  assign s_hready = m_hready;

  // -------------------------------------------------------------------------
  // Error logging
  // -------------------------------------------------------------------------
  logic [7:0]            err_count_reg, err_count_next;
  logic [ADDR_WIDTH-1:0] err_addr_reg, err_addr_next;

  always_comb begin
    err_count_next = err_count_reg;
    err_addr_next  = err_addr_reg;
    if (err_entry) begin
      err_addr_next = m_haddr;
      if (err_clr) begin
        // The clear and the new error land together: count only the new one.
        err_count_next = 8'd1;
      end else if (err_count_reg != 8'hFF) begin
        err_count_next = err_count_reg + 8'd1;
      end
    end else if (err_clr) begin
      err_count_next = 8'd0;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_count_reg <= 8'd0;
      err_addr_reg  <= '0;
    end else begin
      err_count_reg <= err_count_next;
      err_addr_reg  <= err_addr_next;
    end
  end

  assign err_count = err_count_reg;
  assign err_addr  = err_addr_reg;

endmodule

// File: tb/tb_ahb5_lite_interconnect.sv
// ---------------------------------------------------------------------------
// tb_ahb5_lite_interconnect
//
// Directed self-checking bench for ahb5_lite_interconnect configured with
// 4 slaves, base 0, 64 KiB regions and slave 3 secure-only. Slave responses
// are driven directly as static vectors; each scenario task drives its own
// stimulus and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_ahb5_lite_interconnect;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_1111;
  localparam logic [31:0] D2 = 32'hCAFE_0002;
  localparam logic [31:0] D3 = 32'hDEAD_BEEF;

  logic             hclk;
  logic             hresetn;
  logic [AW-1:0]    m_haddr;
  logic [1:0]       m_htrans;
  logic             m_hnonsec;
  logic [DW-1:0]    m_hrdata;
  logic             m_hready;
  logic             m_hresp;
  logic [NS-1:0]    s_hsel;
  logic             s_hready;
  logic [NS*DW-1:0] s_hrdata;
  logic [NS-1:0]    s_hreadyout;
  logic [NS-1:0]    s_hresp;
  logic             err_clr;
  logic [7:0]       err_count;
  logic [AW-1:0]    err_addr;

  int checks;
  int failures;

  ahb5_lite_interconnect #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .NUM_SLAVES   (NS),
    .BASE_ADDR    (32'h0000_0000),
    .REGION_SHIFT (16),
    .SEC_MASK     (4'b1000)
  ) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .m_haddr     (m_haddr),
    .m_htrans    (m_htrans),
    .m_hnonsec   (m_hnonsec),
    .m_hrdata    (m_hrdata),
    .m_hready    (m_hready),
    .m_hresp     (m_hresp),
    .s_hsel      (s_hsel),
    .s_hready    (s_hready),
    .s_hrdata    (s_hrdata),
    .s_hreadyout (s_hreadyout),
    .s_hresp     (s_hresp),
    .err_clr     (err_clr),
    .err_count   (err_count),
    .err_addr    (err_addr)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 more unit later, well away from the next edge.
  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [1:0] trans,
                       input logic nonsec);
    m_haddr   = addr;
    m_htrans  = trans;
    m_hnonsec = nonsec;
    #1;
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    drive(32'h0002_0000, IDLE, 1'b0);
    checks++; if (m_hready !== 1'b1) begin failures++; $display("FAIL reset_hready got=%b exp=1", m_hready); end
    checks++; if (m_hresp !== 1'b0) begin failures++; $display("FAIL reset_hresp got=%b exp=0", m_hresp); end
    checks++; if (m_hrdata !== 32'h0) begin failures++; $display("FAIL reset_hrdata got=%h exp=0", m_hrdata); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (err_addr !== 32'h0) begin failures++; $display("FAIL reset_err_addr got=%h exp=0", err_addr); end
    checks++; if (s_hsel !== 4'b0100) begin failures++; $display("FAIL reset_hsel_comb got=%b exp=0100", s_hsel); end
    next_cycle();
    hresetn = 1'b1;
    drive(32'h0000_0000, IDLE, 1'b0);
    $display("reset: done, hready=%b hresp=%b err_count=%0d", m_hready, m_hresp, err_count);
  endtask

  task automatic test_mapped_write();
    next_cycle();
    drive(32'h0001_0004, NONSEQ, 1'b0);
    checks++; if (s_hsel !== 4'b0010) begin failures++; $display("FAIL t1_hsel got=%b exp=0010", s_hsel); end
    next_cycle();
    drive(32'h0000_0000, IDLE, 1'b0);
    checks++; if (m_hready !== 1'b1) begin failures++; $display("FAIL t1_hready got=%b exp=1", m_hready); end
    checks++; if (m_hresp !== 1'b0) begin failures++; $display("FAIL t1_hresp got=%b exp=0", m_hresp); end
    checks++; if (m_hrdata !== D1) begin failures++; $display("FAIL t1_hrdata got=%h exp=%h", m_hrdata, D1); end
    $display("mapped write 0x00010004: hsel=0010 data phase hready=%b hresp=%b", m_hready, m_hresp);
  endtask

  task automatic test_unmapped();
    next_cycle();
    drive(32'h0005_0000, NONSEQ, 1'b0);
    checks++; if (s_hsel !== 4'b0000) begin failures++; $display("FAIL t2_hsel got=%b exp=0000", s_hsel); end
    next_cycle();
    drive(32'h0000_0000, IDLE, 1'b0);
    checks++; if (m_hready !== 1'b0 || m_hresp !== 1'b1) begin failures++; $display("FAIL t2_err1 got=%b%b exp=01", m_hready, m_hresp); end
    checks++; if (m_hrdata !== 32'h0) begin failures++; $display("FAIL t2_hrdata got=%h exp=0", m_hrdata); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL t2_err_count got=%0d exp=1", err_count); end
    checks++; if (err_addr !== 32'h0005_0000) begin failures++; $display("FAIL t2_err_addr got=%h exp=00050000", err_addr); end
    next_cycle();
    checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b1) begin failures++; $display("FAIL t2_err2 got=%b%b exp=11", m_hready, m_hresp); end
    next_cycle();
    checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b0) begin failures++; $display("FAIL t2_after got=%b%b exp=10", m_hready, m_hresp); end
    $display("unmapped read 0x00050000: two-cycle ERROR, err_count=%0d err_addr=%h", err_count, err_addr);
  endtask

  task automatic test_secure();
    next_cycle();
    drive(32'h0003_0000, NONSEQ, 1'b1);
    checks++; if (s_hsel !== 4'b0000) begin failures++; $display("FAIL t3_ns_hsel got=%b exp=0000", s_hsel); end
    next_cycle();
    drive(32'h0000_0000, IDLE, 1'b0);
    checks++; if (m_hready !== 1'b0 || m_hresp !== 1'b1) begin failures++; $display("FAIL t3_ns_err1 got=%b%b exp=01", m_hready, m_hresp); end
    next_cycle();
    checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b1) begin failures++; $display("FAIL t3_ns_err2 got=%b%b exp=11", m_hready, m_hresp); end
    checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL t3_err_count got=%0d exp=2", err_count); end
    $display("non-secure read 0x00030000: ERROR, err_count=%0d", err_count);
    next_cycle();
    drive(32'h0003_0000, NONSEQ, 1'b0);
    checks++; if (s_hsel !== 4'b1000) begin failures++; $display("FAIL t3_s_hsel got=%b exp=1000", s_hsel); end
    next_cycle();
    drive(32'h0000_0000, IDLE, 1'b0);
    checks++; if (m_hrdata !== D3) begin failures++; $display("FAIL t3_s_hrdata got=%h exp=%h", m_hrdata, D3); end
    checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b0) begin failures++; $display("FAIL t3_s_resp got=%b%b exp=10", m_hready, m_hresp); end
    $display("secure read 0x00030000: hrdata=%h OKAY", m_hrdata);
  endtask

  task automatic test_wait_states();
    next_cycle();
    drive(32'h0002_0000, NONSEQ, 1'b0);
    checks++; if (s_hsel !== 4'b0100) begin failures++; $display("FAIL t4_hsel2 got=%b exp=0100", s_hsel); end
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      s_hreadyout[2] = 1'b0;
      drive(32'h0000_0010, NONSEQ, 1'b0);
      checks++; if (s_hsel !== 4'b0001) begin failures++; $display("FAIL t4_hsel0_c%0d got=%b exp=0001", c, s_hsel); end
      checks++; if (m_hready !== 1'b0 || s_hready !== 1'b0) begin failures++; $display("FAIL t4_stall_c%0d got=%b%b exp=00", c, m_hready, s_hready); end
    end
    next_cycle();
    s_hreadyout[2] = 1'b1;
    #1;
    checks++; if (s_hsel !== 4'b0001) begin failures++; $display("FAIL t4_hsel0_c3 got=%b exp=0001", s_hsel); end
    checks++; if (m_hready !== 1'b1 || m_hrdata !== D2) begin failures++; $display("FAIL t4_done got=%b/%h exp=1/%h", m_hready, m_hrdata, D2); end
    next_cycle();
    drive(32'h0000_0000, IDLE, 1'b0);
    checks++; if (m_hrdata !== D0 || m_hready !== 1'b1) begin failures++; $display("FAIL t4_slave0 got=%b/%h exp=1/%h", m_hready, m_hrdata, D0); end
    $display("wait states: slave2 completed after 3 stalls, slave0 data phase hrdata=%h", m_hrdata);
  endtask

  task automatic test_back_to_back();
    next_cycle();
    drive(32'h0001_0000, NONSEQ, 1'b0);
    next_cycle();
    drive(32'h0002_0000, NONSEQ, 1'b0);
    checks++; if (s_hsel !== 4'b0100 || m_hrdata !== D1) begin failures++; $display("FAIL b2b_s1 got=%b/%h exp=0100/%h", s_hsel, m_hrdata, D1); end
    next_cycle();
    drive(32'h0006_0000, NONSEQ, 1'b0);
    checks++; if (m_hready !== 1'b1 || m_hrdata !== D2) begin failures++; $display("FAIL b2b_s2 got=%b/%h exp=1/%h", m_hready, m_hrdata, D2); end
    // Pipelined errors: the second unmapped transfer is accepted in ERR2.
    next_cycle();
    drive(32'h0007_0000, NONSEQ, 1'b0);
    checks++; if (m_hready !== 1'b0 || m_hresp !== 1'b1) begin failures++; $display("FAIL b2b_e1 got=%b%b exp=01", m_hready, m_hresp); end
    next_cycle();
    checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b1) begin failures++; $display("FAIL b2b_e2 got=%b%b exp=11", m_hready, m_hresp); end
    next_cycle();
    drive(32'h0000_0000, IDLE, 1'b0);
    checks++; if (m_hready !== 1'b0 || m_hresp !== 1'b1) begin failures++; $display("FAIL b2b_e1b got=%b%b exp=01", m_hready, m_hresp); end
    checks++; if (err_count !== 8'd4 || err_addr !== 32'h0007_0000) begin failures++; $display("FAIL b2b_log got=%0d/%h exp=4/00070000", err_count, err_addr); end
    next_cycle();
    next_cycle();
    $display("back-to-back: slaves 1,2 then two pipelined errors, err_count=%0d", err_count);
  endtask

  task automatic test_err_saturation();
    for (int n = 0; n < 256; n++) begin
      drive(32'h0008_0000, NONSEQ, 1'b0);
      next_cycle();
      drive(32'h0000_0000, IDLE, 1'b0);
      next_cycle();
      next_cycle();
      if (n == 250) begin
        checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL sat_reach got=%0d exp=255", err_count); end
      end
    end
    checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", err_count); end
    $display("saturation: 256 errors, err_count=%0d", err_count);
    drive(32'h0009_0000, NONSEQ, 1'b0);
    err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    drive(32'h0000_0000, IDLE, 1'b0);
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL clr_entry got=%0d exp=1", err_count); end
    next_cycle();
    err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    checks++; if (err_count !== 8'd0 || err_addr !== 32'h0009_0000) begin failures++; $display("FAIL clr_alone got=%0d/%h exp=0/00090000", err_count, err_addr); end
    $display("err_clr: with entry ->1, alone ->%0d, err_addr=%h", err_count, err_addr);
  endtask

  task automatic test_async_reset();
    next_cycle();
    drive(32'h0007_0000, NONSEQ, 1'b0);
    next_cycle();
    drive(32'h0000_0000, IDLE, 1'b0);
    checks++; if (m_hready !== 1'b0 || err_count !== 8'd1) begin failures++; $display("FAIL ar_in_err1 got=%b/%0d exp=0/1", m_hready, err_count); end
    hresetn = 1'b0;
    #1;
    checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b0) begin failures++; $display("FAIL ar_resp got=%b%b exp=10", m_hready, m_hresp); end
    checks++; if (err_count !== 8'd0 || err_addr !== 32'h0) begin failures++; $display("FAIL ar_log got=%0d/%h exp=0/0", err_count, err_addr); end
    next_cycle();
    hresetn = 1'b1;
    drive(32'h0009_0000, IDLE, 1'b0);
    next_cycle();
    checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b0 || m_hrdata !== 32'h0) begin failures++; $display("FAIL ar_idle got=%b%b/%h exp=10/0", m_hready, m_hresp, m_hrdata); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL ar_idle_count got=%0d exp=0", err_count); end
    $display("async reset in ERR1: cleared immediately, IDLE unmapped -> OKAY");
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    err_clr     = 1'b0;
    s_hreadyout = 4'hF;
    s_hresp     = 4'h0;
    s_hrdata    = {D3, D2, D1, D0};
    test_reset();
    test_mapped_write();
    test_unmapped();
    test_secure();
    test_wait_states();
    test_back_to_back();
    next_cycle();
    test_err_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
